odu_test_ctrl: RTL and testbench
================================

# odu_test_ctrl

Run controller for the ODU test-data checker. Accepts a start command with a frame budget. Resets the checker and waits for frame lock on the monitored channel. It then counts frames and errored frames from the checker's frame-error flag, and reports pass/fail with a done pulse. It sits between the host/CSR side and the checker, on the same channel stream (valid/fs/rs) that feeds the checker.

## Interface
- CLR_CYCLES, 4: cycles `o_chk_rst` is held high at run start (≥1).
- LOCK_FRAMES, 2: consecutive clean frame starts required before counting (≥1).
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset; one clock domain
- i_start  in  1  run request pulse; honoured only in IDLE
- i_abort  in  1  cancel run; returns to IDLE, no done pulse
- i_num_frames  in  16  frames to count, sampled on accepted start; 0 treated as 1
- i_timeout  in  24  max cycles between frame starts, sampled on start; 0 disables
- i_valid_chid  in  1  channel beat valid
- i_fs_chid  in  1  frame-start flag
- i_rs_chid  in  1  row-start flag
- i_fr_error  in  1  checker frame-error flag
- o_chk_rst  out  1  synchronous reset to checker
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_pass  out  1  result, valid from o_done until next accepted start
- o_timeout  out  1  run ended by timeout
- o_frame_cnt  out  16  frames counted this run
- o_err_cnt  out  16  errored frames this run
- o_state  out  3  IDLE=0, CLEAR=1, ACQUIRE=2, RUN=3, DONE=4

## Operation
- Frame start (FS) is defined as i_valid_chid & i_fs_chid & i_rs_chid. Only FS beats advance lock and counting.
- **IDLE**
  - On i_start & !i_abort: latch i_num_frames and i_timeout, clear all counters, o_pass and o_timeout, then go to CLEAR.
- **CLEAR**
  - o_chk_rst=1 for exactly CLR_CYCLES cycles, then go to ACQUIRE.
  - FS beats in this state are ignored.
- **ACQUIRE**
  - FS with i_fr_error=0: lock_cnt+1.
  - FS with i_fr_error=1: lock_cnt=0.
  - When lock_cnt reaches LOCK_FRAMES, go to RUN on that same FS. Clear the sticky error flag.
- **RUN**
  - Sticky error is set on any valid beat with i_fr_error=1.
  - Each FS closes one frame interval: o_frame_cnt+1. o_err_cnt+1 if (sticky | i_fr_error on that beat). The sticky flag is then cleared.
  - When the updated o_frame_cnt equals the latched num_frames, go to DONE.
- **DONE**
  - o_done=1 for one cycle.
  - o_pass = (o_err_cnt==0) & !o_timeout.
  - Next state is IDLE.
- **Timeout**
  - In ACQUIRE and RUN, a cycle counter runs and clears on every FS.
  - If the latched timeout ≠0 and the counter reaches it, set o_timeout=1, o_pass=0 and go to DONE.
  - If the timeout and the final FS occur in the same cycle, the FS wins (normal completion).
- **Abort**
  - In any non-IDLE state, go to IDLE next cycle. Deassert o_chk_rst. No o_done pulse.
  - Counters freeze at their current values; o_pass=0.
  - If abort and start arrive in the same cycle, abort wins.
- i_start outside IDLE is ignored.
- o_frame_cnt and o_err_cnt saturate at 16'hFFFF. The timeout counter saturates at 24'hFFFFFF.
- Results (counts, o_pass, o_timeout) hold after DONE until the next accepted start.
- State encoding other than 0–4 returns to IDLE.

## Timing
- Reset (async assert, sampled release): state IDLE. All outputs 0, including o_chk_rst.
- Start accepted at edge T:
  - o_busy=1 and o_chk_rst=1 from T+1.
  - o_chk_rst falls after CLR_CYCLES cycles.
  - ACQUIRE from T+CLR_CYCLES+1.
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Counters update on the edge that samples the FS beat.
- Final FS at edge F: state DONE from F+1. o_done=1 during cycle F+1 only, with final counts and o_pass valid in that cycle. IDLE from F+2.
- Back-to-back runs: i_start may be asserted in the first IDLE cycle after DONE.
- Beats with i_valid_chid=0 never count as FS and never set the sticky flag. Timeout cycles still advance on such beats.

## Test plan
- Clean run: num_frames=3, timeout=0, FS every 10 valid beats, i_fr_error=0 → after 2 lock FS and 3 counted FS: o_done pulse, o_frame_cnt=3, o_err_cnt=0, o_pass=1, o_chk_rst high exactly 4 cycles.
- Errored frame: num_frames=4, i_fr_error=1 for one mid-frame beat in interval 2 → o_err_cnt=1, o_frame_cnt=4, o_pass=0.
- Lock retry: in ACQUIRE, FS sequence clean, errored, clean, clean → RUN entered only on the 4th FS (lock_cnt reset by the errored FS).
- Timeout: timeout=50, FS stops after lock → o_done 50 cycles after the last FS, o_timeout=1, o_pass=0. A final FS coinciding with expiry gives o_timeout=0.
- Abort and reset mid-run:
  - i_abort in RUN after 2 frames → IDLE next cycle, no o_done, o_frame_cnt holds 2, o_pass=0.
  - Async rst during CLEAR → o_chk_rst drops immediately, state=0.
- Start corner cases:
  - i_start with i_abort in IDLE → stays IDLE.
  - i_start during RUN → ignored.
  - num_frames=0 → completes after 1 counted frame.

Source files
------------

// File: rtl/odu_test_ctrl.sv
// odu_test_ctrl: run controller for the ODU test-data checker.
// Takes a start command with a frame budget, holds the checker in reset, waits for frame lock
// on the monitored channel, then counts frames and errored frames and reports pass/fail.
// Every output comes from a register or is decoded from the registered state.
module odu_test_ctrl #(
  parameter int unsigned CLR_CYCLES  = 4,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_num_frames,
  input  logic [23:0] i_timeout,
  input  logic        i_valid_chid,
  input  logic        i_fs_chid,
  input  logic        i_rs_chid,
  input  logic        i_fr_error,
  output logic        o_chk_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt,
  output logic [2:0]  o_state
);

  // State encoding is visible on o_state, so the values are fixed.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StClear   = 3'd1;
  localparam logic [2:0] StAcquire = 3'd2;
  localparam logic [2:0] StRun     = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam int unsigned ClrW  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned LockW = $clog2(LOCK_FRAMES + 1);

  localparam logic [ClrW-1:0]  ClrLast    = ClrW'(CLR_CYCLES - 1);
  localparam logic [LockW-1:0] LockTarget = LockW'(LOCK_FRAMES);

  localparam logic [15:0] CntMax = 16'hFFFF;
  localparam logic [23:0] TmoMax = 24'hFF_FFFF;

  logic [2:0]       state_q, state_d;
  logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic [15:0]      num_frames_q, num_frames_d;
  logic [23:0]      timeout_q, timeout_d;
  logic [23:0]      tmo_cnt_q, tmo_cnt_d;
  logic             sticky_q, sticky_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic             tmo_flag_q, tmo_flag_d;

  logic             fs;
  logic             sticky_hit;
  logic [15:0]      frame_inc;
  logic [15:0]      err_inc;
  logic [15:0]      err_after_fs;
  logic [23:0]      tmo_inc;
  logic             tmo_expired;
  logic [LockW-1:0] lock_inc;

  // Beat qualification and saturating increments shared by the next-state logic.
  always_comb begin
    fs           = i_valid_chid & i_fs_chid & i_rs_chid;
    // Invalid beats never contribute to the sticky error.
    sticky_hit   = sticky_q | (i_valid_chid & i_fr_error);
    frame_inc    = (frame_cnt_q == CntMax) ? frame_cnt_q : frame_cnt_q + 16'd1;
    err_inc      = (err_cnt_q == CntMax) ? err_cnt_q : err_cnt_q + 16'd1;
    err_after_fs = sticky_hit ? err_inc : err_cnt_q;
    tmo_inc      = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + 24'd1;
    // A zero timeout disables expiry.
    tmo_expired  = (timeout_q != 24'd0) && (tmo_inc >= timeout_q);
    lock_inc     = lock_cnt_q + LockW'(1);
  end

  // Run sequencing: state, counters and result flags.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    num_frames_d = num_frames_q;
    timeout_d    = timeout_q;
    tmo_cnt_d    = tmo_cnt_q;
    sticky_d     = sticky_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    pass_d       = pass_q;
    tmo_flag_d   = tmo_flag_q;

    if (i_abort && (state_q != StIdle)) begin
      // Abort freezes the counts and leaves a failing result.
      state_d = StIdle;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_start && !i_abort) begin
            num_frames_d = (i_num_frames == 16'd0) ? 16'd1 : i_num_frames;
            timeout_d    = i_timeout;
            clr_cnt_d    = '0;
            lock_cnt_d   = '0;
            tmo_cnt_d    = '0;
            sticky_d     = 1'b0;
            frame_cnt_d  = '0;
            err_cnt_d    = '0;
            pass_d       = 1'b0;
            tmo_flag_d   = 1'b0;
            state_d      = StClear;
          end
        end

        StClear: begin
          // Frame starts seen while the checker is in reset are ignored.
          if (clr_cnt_q == ClrLast) begin
            state_d = StAcquire;
          end else begin
            clr_cnt_d = clr_cnt_q + ClrW'(1);
          end
        end

        StAcquire: begin
          if (fs) begin
            tmo_cnt_d = '0;
            if (i_fr_error) begin
              lock_cnt_d = '0;
            end else if (lock_inc == LockTarget) begin
              lock_cnt_d = '0;
              sticky_d   = 1'b0;
              state_d    = StRun;
            end else begin
              lock_cnt_d = lock_inc;
            end
          end else begin
            tmo_cnt_d = tmo_inc;
            if (tmo_expired) begin
              tmo_flag_d = 1'b1;
              pass_d     = 1'b0;
              state_d    = StDone;
            end
          end
        end

        StRun: begin
          if (fs) begin
            // The frame start closes the interval, including an error on the FS beat itself.
            tmo_cnt_d   = '0;
            frame_cnt_d = frame_inc;
            err_cnt_d   = err_after_fs;
            sticky_d    = 1'b0;
            // A frame start on the expiry cycle wins over the timeout.
            if (frame_inc == num_frames_q) begin
              pass_d  = (err_after_fs == 16'd0) & ~tmo_flag_q;
              state_d = StDone;
            end
          end else begin
            sticky_d  = sticky_hit;
            tmo_cnt_d = tmo_inc;
            if (tmo_expired) begin
              tmo_flag_d = 1'b1;
              pass_d     = 1'b0;
              state_d    = StDone;
            end
          end
        end

        StDone: begin
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      num_frames_q <= 16'd1;
      timeout_q    <= '0;
      tmo_cnt_q    <= '0;
      sticky_q     <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      pass_q       <= 1'b0;
      tmo_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      num_frames_q <= num_frames_d;
      timeout_q    <= timeout_d;
      tmo_cnt_q    <= tmo_cnt_d;
      sticky_q     <= sticky_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      pass_q       <= pass_d;
      tmo_flag_q   <= tmo_flag_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_chk_rst   = (state_q == StClear);
    o_busy      = (state_q != StIdle);
    o_done      = (state_q == StDone);
    o_pass      = pass_q;
    o_timeout   = tmo_flag_q;
    o_frame_cnt = frame_cnt_q;
    o_err_cnt   = err_cnt_q;
    o_state     = state_q;
  end

endmodule

// File: tb/tb_odu_test_ctrl.sv
// Bench for odu_test_ctrl: per-run stimulus tables checked cycle by cycle against an
// event-level reference derived from the run rules (edge indices, frame intervals, gaps).
module tb_odu_test_ctrl;

  localparam int CLR  = 4;
  localparam int LOCK = 2;
  localparam int L    = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort;
  logic [15:0] i_num_frames;
  logic [23:0] i_timeout;
  logic        i_valid_chid, i_fs_chid, i_rs_chid, i_fr_error;
  logic        o_chk_rst, o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_frame_cnt, o_err_cnt;
  logic [2:0]  o_state;

  odu_test_ctrl #(
    .CLR_CYCLES (CLR),
    .LOCK_FRAMES(LOCK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_num_frames(i_num_frames),
    .i_timeout   (i_timeout),
    .i_valid_chid(i_valid_chid),
    .i_fs_chid   (i_fs_chid),
    .i_rs_chid   (i_rs_chid),
    .i_fr_error  (i_fr_error),
    .o_chk_rst   (o_chk_rst),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_timeout   (o_timeout),
    .o_frame_cnt (o_frame_cnt),
    .o_err_cnt   (o_err_cnt),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus per edge k (edge 0 carries the start command).
  bit v_a[L], f_a[L], r_a[L], e_a[L], s_a[L], a_a[L];
  // Expected observations just after edge k.
  int st_e[L], fc_e[L], ec_e[L];
  bit ps_e[L], to_e[L];
  int end_edge;

  // Reference: walk the beat table edge by edge using the run rules.
  task automatic build_model(input int nf, input int tmo);
    int nfe, lock, fr, er, last, st, nst;
    bit sticky, ps, to, fsb;
    nfe = (nf == 0) ? 1 : nf;
    lock = 0; fr = 0; er = 0; last = CLR; sticky = 0; ps = 0; to = 0;
    end_edge = -1;
    st_e[0] = 1; fc_e[0] = 0; ec_e[0] = 0; ps_e[0] = 0; to_e[0] = 0;
    for (int k = 1; k < L; k++) begin
      st  = st_e[k-1];
      nst = st;
      fsb = v_a[k] & f_a[k] & r_a[k];
      if (end_edge >= 0) begin
        nst = 0;
      end else if (a_a[k]) begin
        nst = 0; ps = 0; end_edge = k;
      end else begin
        case (st)
          1: nst = (k == CLR) ? 2 : 1;
          2: begin
            if (fsb) begin
              last = k;
              if (e_a[k]) lock = 0;
              else begin
                lock++;
                if (lock == LOCK) begin nst = 3; sticky = 0; end
              end
            end else if (tmo != 0 && k - last >= tmo) begin
              nst = 4; to = 1; ps = 0;
            end
          end
          3: begin
            if (v_a[k] && e_a[k]) sticky = 1;
            if (fsb) begin
              last = k;
              if (fr < 65535) fr++;
              if (sticky && er < 65535) er++;
              sticky = 0;
              if (fr == nfe) begin nst = 4; ps = (er == 0); end
            end else if (tmo != 0 && k - last >= tmo) begin
              nst = 4; to = 1; ps = 0;
            end
          end
          4: begin nst = 0; end_edge = k; end
          default: nst = 0;
        endcase
      end
      st_e[k] = nst; fc_e[k] = fr; ec_e[k] = er; ps_e[k] = ps; to_e[k] = to;
    end
  endtask

  task automatic run_case(input string name, input int nf, input int tmo, input int period,
                          input int vld_pct, input int err_rate, input int err_at,
                          input int fs_stop, input int abort_at, input bit noise);
    bit grid;
    for (int k = 0; k < L; k++) begin
      grid   = (k > 0) && (k % period == 0) && (fs_stop == 0 || k <= fs_stop);
      v_a[k] = (vld_pct >= 100) ? 1'b1 : ($urandom_range(99) < vld_pct);
      f_a[k] = grid | (noise && $urandom_range(31) == 0);
      r_a[k] = grid | (noise && $urandom_range(31) == 0);
      e_a[k] = (k == err_at) | (err_rate > 0 && $urandom_range(err_rate - 1) == 0);
      s_a[k] = ($urandom_range(3) == 0);
      a_a[k] = (k == abort_at);
    end
    build_model(nf, tmo);
    if (end_edge < 0 || end_edge > L - 4) begin
      a_a[L-4] = 1'b1;
      build_model(nf, tmo);
    end
    for (int k = 0; k <= end_edge + 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        i_start = 1'b1; i_abort = 1'b0;
        i_num_frames = 16'(nf); i_timeout = 24'(tmo);
        i_valid_chid = 1'b0; i_fs_chid = 1'b0; i_rs_chid = 1'b0; i_fr_error = 1'b0;
      end else if (k <= end_edge) begin
        i_start = s_a[k]; i_abort = a_a[k];
        i_num_frames = 16'($urandom); i_timeout = 24'($urandom);
        i_valid_chid = v_a[k]; i_fs_chid = f_a[k]; i_rs_chid = r_a[k]; i_fr_error = e_a[k];
      end else begin
        i_start = 1'b0; i_abort = 1'b0;
        i_valid_chid = 1'b0; i_fs_chid = 1'b0; i_rs_chid = 1'b0; i_fr_error = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("%s.k%0d.state", name, k), 32'(o_state), 32'(st_e[k]));
      check($sformatf("%s.k%0d.busy", name, k), 32'(o_busy), 32'(st_e[k] != 0));
      check($sformatf("%s.k%0d.chk_rst", name, k), 32'(o_chk_rst), 32'(st_e[k] == 1));
      check($sformatf("%s.k%0d.done", name, k), 32'(o_done), 32'(st_e[k] == 4));
      check($sformatf("%s.k%0d.frame_cnt", name, k), 32'(o_frame_cnt), 32'(fc_e[k]));
      check($sformatf("%s.k%0d.err_cnt", name, k), 32'(o_err_cnt), 32'(ec_e[k]));
      check($sformatf("%s.k%0d.pass", name, k), 32'(o_pass), 32'(ps_e[k]));
      check($sformatf("%s.k%0d.timeout", name, k), 32'(o_timeout), 32'(to_e[k]));
    end
  endtask

  initial begin
    int held_fc;
    rst = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_num_frames = '0; i_timeout = '0;
    i_valid_chid = 1'b0; i_fs_chid = 1'b0; i_rs_chid = 1'b0; i_fr_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", 32'(o_state), 32'd0);
    check("reset.chk_rst", 32'(o_chk_rst), 32'd0);
    check("reset.busy", 32'(o_busy), 32'd0);
    check("reset.done", 32'(o_done), 32'd0);
    check("reset.pass", 32'(o_pass), 32'd0);
    check("reset.timeout", 32'(o_timeout), 32'd0);
    check("reset.frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("reset.err_cnt", 32'(o_err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //        name        nf tmo per vld err err_at stop abort noise
    run_case("clean",      3,  0, 10, 100, 0,  -1,  0,  -1, 1'b0);
    run_case("errored",    4,  0, 10, 100, 0,  35,  0,  -1, 1'b0);
    run_case("lockretry",  2,  0, 10, 100, 0,  20,  0,  -1, 1'b0);
    run_case("timeout",    5, 50, 10, 100, 0,  -1, 30,  -1, 1'b0);
    run_case("coincide",   2, 10, 10, 100, 0,  -1,  0,  -1, 1'b0);
    run_case("abort",      5,  0, 10, 100, 0,  -1,  0,  45, 1'b0);
    held_fc = fc_e[end_edge];

    // Start together with abort in IDLE must not launch a run.
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1; i_num_frames = 16'd3; i_timeout = '0;
    @(posedge clk);
    #1;
    check("start_abort.state", 32'(o_state), 32'd0);
    check("start_abort.busy", 32'(o_busy), 32'd0);
    check("start_abort.frame_cnt", 32'(o_frame_cnt), 32'(held_fc));
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;

    run_case("nf_zero",    0,  0,  8, 100, 0,  -1,  0,  -1, 1'b0);

    // Asynchronous reset while the checker is held in reset.
    @(negedge clk);
    i_start = 1'b1; i_num_frames = 16'd3; i_timeout = '0;
    @(negedge clk);
    i_start = 1'b0;
    check("rst_clear.pre_chk_rst", 32'(o_chk_rst), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_clear.chk_rst", 32'(o_chk_rst), 32'd0);
    check("rst_clear.state", 32'(o_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      int tmo, err_rate, stop, abort_at;
      tmo      = ($urandom_range(2) == 0) ? int'($urandom_range(40, 5)) : 0;
      err_rate = ($urandom_range(1) == 0) ? int'($urandom_range(60, 20)) : 0;
      stop     = ($urandom_range(3) == 0) ? int'($urandom_range(120, 20)) : 0;
      abort_at = ($urandom_range(4) == 0) ? int'($urandom_range(150, 2)) : -1;
      run_case($sformatf("rand%0d", i), int'($urandom_range(6)), tmo,
               int'($urandom_range(12, 4)), int'($urandom_range(100, 60)), err_rate, -1,
               stop, abort_at, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
